// File: rtl/instr_enc.sv
// Host-request to SPI byte-pair encoder: a command byte then a data byte per cs_n frame.
// Optional watchdog on CMD/DATA enabled by defining INSTR_ENC_TIMEOUT_EN.
module instr_enc #(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       cs_n,
  output logic [7:0] tx_byte,
  output logic       tx_start,
  input  logic       byte_sync,
  input  logic [7:0] rx_byte
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, GAP} state_t;

  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  localparam state_t     POST_ST  = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t     state, state_nx;
  logic       lat_write;
  logic [7:0] lat_wdata;
  logic [3:0] gap_cnt;
  logic       sync_ok;
  logic       hs, to_data, done, tout, tmo;

  // A byte_sync landing in the same cycle as tx_start belongs to no byte we sent.
  assign sync_ok   = byte_sync & ~tx_start;
  assign req_ready = (state == IDLE) & ~rst;

`ifdef INSTR_ENC_TIMEOUT_EN
  logic [7:0] wd_cnt;
  // wd_cnt equals cycles since the last tx_start; timeout lands on cycle 255.
  assign tmo = (wd_cnt == 8'd254);
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    hs       = 1'b0;
    to_data  = 1'b0;
    done     = 1'b0;
    tout     = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        hs       = 1'b1;
        state_nx = CMD;
      end
      CMD: if (sync_ok) begin
        to_data  = 1'b1;
        state_nx = DATA;
      end else if (tmo) begin
        done     = 1'b1;
        tout     = 1'b1;
        state_nx = POST_ST;
      end
      DATA: if (sync_ok) begin
        done     = 1'b1;
        state_nx = POST_ST;
      end else if (tmo) begin
        done     = 1'b1;
        tout     = 1'b1;
        state_nx = POST_ST;
      end
      GAP: if (gap_cnt == 4'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_write <= 1'b0;
      lat_wdata <= '0;
      gap_cnt   <= '0;
      cs_n      <= 1'b1;
      tx_byte   <= '0;
      tx_start  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nx;
      tx_start  <= 1'b0;
      rsp_valid <= 1'b0;
      if (hs) begin
        lat_write <= req_write;
        lat_wdata <= req_wdata;
        cs_n      <= 1'b0;
        tx_byte   <= {req_write, 1'b0, req_addr};
        tx_start  <= 1'b1;
      end
      if (to_data) begin
        tx_byte  <= lat_write ? lat_wdata : 8'h00;
        tx_start <= 1'b1;
      end
      if (done) begin
        rsp_valid <= 1'b1;
        cs_n      <= 1'b1;
        gap_cnt   <= GAP_LOAD;
        if (!tout && !lat_write) rsp_rdata <= rx_byte;
      end
      if (state == GAP && gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
    end
  end

`ifdef INSTR_ENC_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt  <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (hs || to_data)                   wd_cnt <= '0;
      else if (state == CMD || state == DATA) wd_cnt <= wd_cnt + 8'd1;
      if (done) rsp_err <= tout;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_enc.sv
// Directed bench for instr_enc: writes, reads, back-to-back gap, spurious sync, reset abort.
// Timeout scenario runs only when INSTR_ENC_TIMEOUT_EN is defined.
module tb_instr_enc;
  localparam int unsigned GAP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_write;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       cs_n, tx_start, byte_sync;
  logic [7:0] tx_byte, rx_byte;

  int checks = 0;
  int errors = 0;
  int rsp_pulses = 0;

  always #5 clk = ~clk;

  instr_enc #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cs_n(cs_n), .tx_byte(tx_byte), .tx_start(tx_start),
    .byte_sync(byte_sync), .rx_byte(rx_byte)
  );

  always @(negedge clk) if (rsp_valid) rsp_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(req_ready), 32'd1);
  endtask

  // Entered at a negedge with req_ready high; leaves at a negedge with req_ready high.
  task automatic run_txn(input logic w, input logic [5:0] a, input logic [7:0] wd,
                         input logic [7:0] rx, input logic [7:0] exp_rd,
                         input int unsigned dly, input bit early_sync);
    int n;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_wdata = 8'h00;
    check("cmd_start", 32'(tx_start), 32'd1);
    check("cmd_byte",  32'(tx_byte),  32'({w, 1'b0, a}));
    check("cmd_csn",   32'(cs_n),     32'd0);
    check("cmd_ready", 32'(req_ready), 32'd0);
    if (early_sync) begin
      byte_sync = 1'b1; rx_byte = 8'hEE;
      @(negedge clk);
      byte_sync = 1'b0;
      check("early_sync_ignored", 32'({tx_start, tx_byte}), 32'({1'b0, w, 1'b0, a}));
    end
    repeat (dly) @(negedge clk);
    byte_sync = 1'b1; rx_byte = 8'h5A;
    @(negedge clk);
    byte_sync = 1'b0;
    check("data_start", 32'(tx_start), 32'd1);
    check("data_byte",  32'(tx_byte),  w ? 32'(wd) : 32'd0);
    check("data_csn",   32'(cs_n),     32'd0);
    repeat (dly) @(negedge clk);
    byte_sync = 1'b1; rx_byte = rx;
    @(negedge clk);
    byte_sync = 1'b0;
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_err",   32'(rsp_err),   32'd0);
    check("rsp_csn",   32'(cs_n),      32'd1);
    check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    end
    check("gap_len", 32'(n), 32'(GAP));
    check("gap_csn", 32'(cs_n), 32'd1);
  endtask

  initial begin
    int p;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    byte_sync = 1'b0; rx_byte = '0;
    repeat (3) @(negedge clk);
    check("rst_csn",      32'(cs_n),      32'd1);
    check("rst_tx_start", 32'(tx_start),  32'd0);
    check("rst_tx_byte",  32'(tx_byte),   32'd0);
    check("rst_rsp",      32'(rsp_valid), 32'd0);
    check("rst_rdata",    32'(rsp_rdata), 32'd0);
    check("rst_err",      32'(rsp_err),   32'd0);
    check("rst_ready",    32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(req_ready), 32'd1);

    // Write 05/A7: command 85, data A7, rdata stays 00.
    run_txn(1'b1, 6'h05, 8'hA7, 8'h99, 8'h00, 1, 1'b0);
    // Read 12 with a sync coincident with tx_start: command 12, data 00, rdata 3C.
    run_txn(1'b0, 6'h12, 8'hFF, 8'h3C, 8'h3C, 3, 1'b1);
    // Back-to-back pair.
    run_txn(1'b1, 6'h3F, 8'h01, 8'h77, 8'h3C, 2, 1'b0);
    run_txn(1'b0, 6'h00, 8'h00, 8'hC3, 8'hC3, 1, 1'b0);

    // Spurious sync in IDLE.
    byte_sync = 1'b1; rx_byte = 8'h11;
    @(negedge clk);
    byte_sync = 1'b0;
    check("spur_ready", 32'(req_ready), 32'd1);
    check("spur_out",   32'({cs_n, tx_start, rsp_valid}), 32'b100);
    @(negedge clk);
    check("spur_ready2", 32'(req_ready), 32'd1);

    // Reset abort during DATA.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 6'h2A;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_cmd", 32'(tx_byte), 32'h2A);
    @(negedge clk);
    byte_sync = 1'b1;
    @(negedge clk);
    byte_sync = 1'b0;
    check("abort_data_start", 32'(tx_start), 32'd1);
    p = rsp_pulses;
    rst = 1'b1; req_valid = 1'b1;
    #1;
    check("abort_csn",   32'(cs_n),      32'd1);
    check("abort_tx",    32'({tx_start, tx_byte}), 32'd0);
    check("abort_rdata", 32'(rsp_rdata), 32'd0);
    @(negedge clk);
    byte_sync = 1'b1; rx_byte = 8'hAB;
    @(negedge clk);
    byte_sync = 1'b0;
    check("abort_ready_in_rst", 32'(req_ready), 32'd0);
    check("abort_no_start",     32'(tx_start),  32'd0);
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("abort_no_rsp", 32'(rsp_pulses), 32'(p));
    check("abort_idle",   32'({req_ready, cs_n}), 32'b11);
    run_txn(1'b0, 6'h01, 8'h00, 8'h42, 8'h42, 1, 1'b0);

`ifdef INSTR_ENC_TIMEOUT_EN
    begin
      int n;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h10; req_wdata = 8'h55;
      @(negedge clk);
      req_valid = 1'b0;
      check("tmo_start", 32'(tx_start), 32'd1);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rsp_valid && n < 400);
      check("tmo_latency", 32'(n), 32'd255);
      check("tmo_err",     32'(rsp_err),   32'd1);
      check("tmo_csn",     32'(cs_n),      32'd1);
      check("tmo_rdata",   32'(rsp_rdata), 32'h42);
      wait_ready();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/instr_enc.md
INSTR_ENC -- requirements
Module: instr_enc

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2, number of clk cycles cs_n stays high between transactions (0..15).
REQ-002 SHALL have port clk  in  1  single clock; all state on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous assert, active-high.
REQ-004 SHALL have port req_valid  in  1  host request present.
REQ-005 SHALL have port req_ready  out  1  encoder accepts request this cycle.
REQ-006 SHALL have port req_write  in  1  1=write, 0=read.
REQ-007 SHALL have port req_addr  in  6  register address.
REQ-008 SHALL have port req_wdata  in  8  write data.
REQ-009 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata  out  8  read data, valid with rsp_valid on reads.
REQ-011 SHALL have port rsp_err  out  1  timeout flag, valid with rsp_valid.
REQ-012 SHALL have port cs_n  out  1  SPI chip select, active-low, frames one transaction.
REQ-013 SHALL have port tx_byte  out  8  byte to SPI master shifter.
REQ-014 SHALL have port tx_start  out  1  one-cycle pulse: shift tx_byte now.
REQ-015 SHALL have port byte_sync  in  1  one-cycle pulse: byte exchange complete.
REQ-016 SHALL have port rx_byte  in  8  byte received, valid with byte_sync.

Function
REQ-017 SHALL implement FSM states IDLE, CMD, DATA, GAP.
REQ-018 SHALL drive req_ready = 1 only in IDLE; handshake = req_valid & req_ready.
REQ-019 On handshake SHALL latch write/addr/wdata, next cycle: cs_n=0, tx_byte={req_write,1'b0,req_addr}, tx_start=1, state CMD.
REQ-020 In CMD, on byte_sync SHALL next cycle drive tx_byte = latched wdata (write) or 8'h00 (read), pulse tx_start, state DATA; rx_byte ignored.
REQ-021 In DATA, on byte_sync SHALL next cycle pulse rsp_valid, rsp_err=0, cs_n=1, state GAP (IDLE if GAP_CYCLES=0).
REQ-022 SHALL update rsp_rdata with rx_byte only on read completion; writes leave rsp_rdata unchanged.
REQ-023 GAP SHALL last exactly GAP_CYCLES cycles, then IDLE.
REQ-024 byte_sync in IDLE or GAP SHALL be ignored; byte_sync coincident with tx_start SHALL be ignored.
REQ-025 tx_start and rsp_valid SHALL never exceed one cycle; tx_byte SHALL hold until the next tx_start.
REQ-026 Minimum transaction, handshake to rsp_valid, SHALL be 3 cycles plus two shifter byte times.

Reset
REQ-027 While rst=1: state IDLE, cs_n=1, tx_start=0, tx_byte=8'h00, rsp_valid=0, rsp_rdata=8'h00, rsp_err=0, counters 0.
REQ-028 rst asserted mid-transaction SHALL abort immediately, no rsp_valid; requests presented during rst SHALL not be accepted.

Configuration
REQ-029 With INSTR_ENC_TIMEOUT_EN defined: an 8-bit watchdog SHALL count cycles in CMD/DATA, cleared on each tx_start; reaching 255 without byte_sync SHALL raise cs_n, pulse rsp_valid with rsp_err=1, leave rsp_rdata unchanged, enter GAP.
REQ-030 Without INSTR_ENC_TIMEOUT_EN: no watchdog, rsp_err tied 0, CMD/DATA wait indefinitely.

Verification
REQ-031 Write addr 6'h05 data 8'hA7 -> tx bytes 8'h85 then 8'hA7 under one cs_n low window; rsp_valid=1 once, rsp_err=0.
REQ-032 Read addr 6'h12, rx_byte=8'h3C on second byte_sync -> tx bytes 8'h12, 8'h00; rsp_rdata=8'h3C with rsp_valid.
REQ-033 Back-to-back requests, GAP_CYCLES=2 -> cs_n high exactly 2 cycles between frames, req_ready low throughout transaction.
REQ-034 Spurious byte_sync in IDLE, then rst pulse during DATA -> no state change from the spurious pulse; after rst cs_n=1, no rsp_valid, next request runs normally.
REQ-035 INSTR_ENC_TIMEOUT_EN defined, byte_sync withheld after command byte -> rsp_valid with rsp_err=1 exactly 255 cycles after tx_start, cs_n=1.
